shift_sequencer: RTL
====================

# shift_sequencer

Multi-cycle controller that extends the ALU's 4-bit shift datapath, which moves 0–3 bit positions per pass, to shift amounts of 0–7. It accepts one shift request over a valid/ready handshake and applies successive passes of at most 3 bits until the full amount is consumed. It then returns the result and a shifted-out-ones flag over a second valid/ready handshake. It sits between the ALU opcode decoder and the shifter result mux.

## Interface
- WIDTH, 4: operand/result width (only 4 is supported).
- AMT_W, 3: width of shift-amount field.
- MAX_STEP, 3: largest per-pass shift, matching the 2-bit per-pass amount.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_op  in  4  opcode. req_op[2]=0 is a left shift; req_op[2]=1 is a right shift. 4'b0101 is an arithmetic right shift.
- req_b  in  WIDTH  operand to shift.
- req_amt  in  AMT_W  total shift amount, 0–7.
- req_cin  in  1  fill bit for non-arithmetic shifts.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_data  out  WIDTH  shifted result.
- rsp_lost  out  1  at least one 1-bit was shifted out of the operand.
- busy  out  1  high in SHIFT or DONE.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE. Reset enters IDLE.
- **Accept.** A request is accepted when req_valid && req_ready. On acceptance the block latches op, cin, b into the working register, and amt into the remaining count, and clears the lost flag.
  - If amt==0, the next state is DONE.
  - Otherwise the next state is SHIFT.
- **Each SHIFT cycle:**
  - step = min(remaining, 3).
  - The working register is shifted by step in the direction given by op[2].
  - remaining -= step.
  - The lost flag is ORed with any 1 among the bits shifted out.
  - When the new remaining value is 0, the next state is DONE; otherwise the FSM stays in SHIFT.
- **Fill bit:**
  - Arithmetic (op==4'b0101): the current MSB of the working register, so the sign is preserved across passes.
  - All other opcodes: the latched cin, applied on every pass.
  - Opcodes other than 0101 with op[2]=1 are logical right shifts filled with cin.
- **DONE:**
  - rsp_valid=1.
  - rsp_data and rsp_lost are driven from registers and held stable until the rsp handshake.
  - On rsp_ready the FSM returns to IDLE.
  - rsp_ready while not in DONE is ignored.
- **Request side rules:**
  - req_valid is ignored outside IDLE.
  - The latched request fields are not affected by input changes after acceptance.
- **Throughput:** there is no IDLE bypass, so back-to-back requests are separated by at least one IDLE cycle.
- **Reset:** rst_n low at any time, including mid-SHIFT or in DONE, aborts the operation immediately and produces no response.

## Timing
- **Reset values:** state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_lost=0, busy=0, remaining=0.
- **Latency:** with acceptance at edge T, rsp_valid rises after edge T+1+ceil(amt/3).
  - amt 0 → T+1.
  - amt 1–3 → T+2.
  - amt 4–6 → T+3.
  - amt 7 → T+4.
- **Step sequence:** amt 7 is performed as passes of 3, 3, 1; amt 5 as 3, 2.
- **Response handshake:** the response completes on the edge where rsp_valid && rsp_ready. req_ready rises in the following cycle.
- **Output timing:** all outputs are registered or decoded from registered state only. There is no combinational path from the req_* inputs to any output.

## Test plan
- **Logical left.** op=0000, b=0011, amt=2, cin=0.
  - Required: rsp_data=1100, rsp_lost=0.
  - rsp_valid at T+2.
  - busy high for 2 cycles.
- **Arithmetic right.** op=0101, b=1000, amt=7.
  - Required: rsp_data=1111, rsp_lost=0.
  - rsp_valid at T+4.
  - Exactly 3 SHIFT cycles with steps 3, 3, 1.
- **Logical right with cin fill.** op=0100, b=1011, amt=5, cin=1.
  - Required: rsp_data=1111, rsp_lost=1.
  - rsp_valid at T+3.
- **Zero amount.** amt=0, b=1010, op=0000.
  - Required: rsp_data=1010, rsp_lost=0.
  - rsp_valid at T+1, with no SHIFT cycle.
- **Backpressure.** rsp_ready is held low for 5 cycles in DONE while a second req_valid is held high.
  - Required: req_ready stays 0 and rsp_data/rsp_lost stay stable.
  - The second request is accepted one cycle after the rsp handshake cycle.
- **Reset mid-operation.** rst_n is pulled low during the second SHIFT cycle of an amt=7 request.
  - Required: all outputs immediately return to their reset values and no rsp_valid is produced.
  - A new request (op=0000, b=0001, amt=3) after release yields 1000 at T+2.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: stretches a 0-3 bit per-pass shifter to 0-7 bit
// shifts, with valid/ready handshakes on both the request and response sides.
module shift_sequencer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned AMT_W    = 3,
  parameter int unsigned MAX_STEP = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_b,
  input  logic [AMT_W-1:0] req_amt,
  input  logic             req_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_lost,
  output logic             busy
);

  localparam int unsigned     STEP_W = 2;
  localparam int unsigned     OP_W   = 4;
  localparam logic [OP_W-1:0] OP_SRA = 4'b0101;
  localparam logic [WIDTH-1:0] ONES  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_d;
  logic   ready_d, valid_d, busy_d;

  logic [WIDTH-1:0]   work, work_nxt;
  logic [WIDTH-1:0]   live, live_nxt;
  logic [AMT_W-1:0]   rem, rem_nxt;
  logic [OP_W-1:0]    op;
  logic               cin, lost, lost_pass;
  logic               accept;
  logic [STEP_W-1:0]  step;
  logic               fill_bit;
  logic [WIDTH-1:0]   fill_mask;
  logic [2*WIDTH-1:0] wide_w, wide_l;

  assign accept   = req_valid && (state == IDLE);
  assign rsp_data = work;
  assign rsp_lost = lost;

  // State register and registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      req_ready <= ready_d;
      rsp_valid <= valid_d;
      busy      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (req_valid) state_d = (req_amt == '0) ? DONE : SHIFT;
      SHIFT:   if (rem_nxt == '0) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state, so outputs leave the flops directly
  always_comb begin
    ready_d = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  // One shifter pass; live marks positions still holding original operand bits,
  // so fill bits and the replicated sign of an arithmetic shift never count as lost
  always_comb begin
    step      = (rem > AMT_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : rem[STEP_W-1:0];
    rem_nxt   = rem - AMT_W'(step);
    fill_bit  = (op == OP_SRA) ? work[WIDTH-1] : cin;
    wide_w    = '0;
    wide_l    = '0;
    fill_mask = '0;
    work_nxt  = work;
    live_nxt  = live;
    lost_pass = 1'b0;
    if (op[2]) begin
      wide_w    = {work, WIDTH'(0)} >> step;
      wide_l    = {live, WIDTH'(0)} >> step;
      fill_mask = ~(ONES >> step);
      work_nxt  = wide_w[2*WIDTH-1:WIDTH] | ({WIDTH{fill_bit}} & fill_mask);
      live_nxt  = wide_l[2*WIDTH-1:WIDTH];
      lost_pass = |(wide_w[WIDTH-1:0] & wide_l[WIDTH-1:0]);
    end else begin
      wide_w    = {WIDTH'(0), work} << step;
      wide_l    = {WIDTH'(0), live} << step;
      fill_mask = ~(ONES << step);
      work_nxt  = wide_w[WIDTH-1:0] | ({WIDTH{fill_bit}} & fill_mask);
      live_nxt  = wide_l[WIDTH-1:0];
      lost_pass = |(wide_w[2*WIDTH-1:WIDTH] & wide_l[2*WIDTH-1:WIDTH]);
    end
  end

  // Working registers: loaded on accept, advanced once per SHIFT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      live <= '0;
      rem  <= '0;
      op   <= '0;
      cin  <= 1'b0;
      lost <= 1'b0;
    end else if (accept) begin
      work <= req_b;
      live <= (req_op == OP_SRA) ? {1'b0, {(WIDTH-1){1'b1}}} : ONES;
      rem  <= req_amt;
      op   <= req_op;
      cin  <= req_cin;
      lost <= 1'b0;
    end else if (state == SHIFT) begin
      work <= work_nxt;
      live <= live_nxt;
      rem  <= rem_nxt;
      lost <= lost | lost_pass;
    end
  end

endmodule
